controle_pista: RTL and testbench

CONTROLE_PISTA -- requirements
Module: controle_pista

---
 rtl/pista_pkg.sv | 17 +
 rtl/detector_borda.sv | 24 ++
 rtl/controle_pista.sv | 119 +++++++++++
 tb/tb_controle_pista.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pista_pkg.sv
// pista_pkg -- shared definitions for the track game controller and the
// display mapper that decodes estado_atual.
//   estado_t  : FSM state encodings (visible on estado_atual)
//   POS_FINAL : last track position; reaching it ends the round
package pista_pkg;

    typedef enum logic [2:0] {
        OCIOSO          = 3'b000,
        JOGANDO         = 3'b001,
        SUCESSO_TOTAL   = 3'b010,
        SUCESSO_PARCIAL = 3'b011,
        FALHA           = 3'b100
    } estado_t;

    localparam logic [2:0] POS_FINAL = 3'd5;

endpackage

// File: rtl/detector_borda.sv
// detector_borda -- rising-edge detector for a synchronous level input.
//   clk     : clock
//   reset_n : asynchronous active-low reset (clears the stored copy)
//   entrada : level input
//   borda   : high for the cycle where entrada is 1 and was 0 last cycle
module detector_borda (
    input  logic clk,
    input  logic reset_n,
    input  logic entrada,
    output logic borda
);

    logic anterior;

    // The stored copy tracks the input every cycle regardless of what the
    // consumer is doing, so a level held across a mode change is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) anterior <= 1'b0;
        else          anterior <= entrada;
    end

    assign borda = entrada & ~anterior;

endmodule

// File: rtl/controle_pista.sv
// controle_pista -- track game controller. A start request opens a timed
// round; each rising edge of avancar moves one position along the track.
// Reaching POS_FINAL early gives total success, late gives partial success,
// running out of time gives failure. Result states hold for TEMPO_RESULTADO
// cycles, then the controller returns to idle.
//   clk           : clock, all state changes on rising edge
//   reset_n       : asynchronous active-low reset
//   iniciar       : start request, acts only in OCIOSO
//   avancar       : advance button, only its rising edge acts (in JOGANDO)
//   estado_atual  : registered FSM state
//   posicao_atual : registered track position 0..5
//   em_jogo       : registered, high exactly while in JOGANDO
module controle_pista
    import pista_pkg::*;
#(
    parameter int TEMPO_LIMITE    = 20,
    parameter int TEMPO_RESULTADO = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       avancar,
    output logic [2:0] estado_atual,
    output logic [2:0] posicao_atual,
    output logic       em_jogo
);

    // tempo never exceeds TEMPO_LIMITE-1 (it stops counting on exit), and
    // the result counter never exceeds TEMPO_RESULTADO-1.
    localparam int TW = $clog2(TEMPO_LIMITE);
    localparam int RW = (TEMPO_RESULTADO > 1) ? $clog2(TEMPO_RESULTADO) : 1;

    localparam logic [TW-1:0] T_ULTIMO = TW'(TEMPO_LIMITE - 1);
    localparam logic [TW-1:0] T_METADE = TW'(TEMPO_LIMITE / 2);
    localparam logic [RW-1:0] R_ULTIMO = RW'(TEMPO_RESULTADO - 1);

    estado_t       estado, estado_n;
    logic [2:0]    posicao, posicao_n;
    logic [TW-1:0] tempo, tempo_n;
    logic [RW-1:0] cont, cont_n;
    logic          borda;
    logic          completa;

    detector_borda u_borda (
        .clk     (clk),
        .reset_n (reset_n),
        .entrada (avancar),
        .borda   (borda)
    );

    always_comb begin
        estado_n  = estado;
        posicao_n = posicao;
        tempo_n   = tempo;
        cont_n    = cont;
        completa  = 1'b0;
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    estado_n  = JOGANDO;
                    posicao_n = 3'd0;
                    tempo_n   = '0;
                end
            end
            JOGANDO: begin
                completa = borda && (posicao == POS_FINAL - 3'd1);
                if (borda && posicao != POS_FINAL)
                    posicao_n = posicao + 3'd1;
                // A completing edge wins over the timeout; at the last cycle
                // tempo is past the midpoint so it lands on partial success.
                if (completa) begin
                    estado_n = (tempo < T_METADE) ? SUCESSO_TOTAL : SUCESSO_PARCIAL;
                    cont_n   = '0;
                end else if (tempo == T_ULTIMO) begin
                    estado_n = FALHA;
                    cont_n   = '0;
                end else begin
                    tempo_n = tempo + 1'b1;
                end
            end
            SUCESSO_TOTAL, SUCESSO_PARCIAL, FALHA: begin
                if (cont == R_ULTIMO) begin
                    estado_n  = OCIOSO;
                    posicao_n = 3'd0;
                    cont_n    = '0;
                end else begin
                    cont_n = cont + 1'b1;
                end
            end
            default: begin
                // unused encodings recover to idle
                estado_n  = OCIOSO;
                posicao_n = 3'd0;
                tempo_n   = '0;
                cont_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado  <= OCIOSO;
            posicao <= 3'd0;
            tempo   <= '0;
            cont    <= '0;
            em_jogo <= 1'b0;
        end else begin
            estado  <= estado_n;
            posicao <= posicao_n;
            tempo   <= tempo_n;
            cont    <= cont_n;
            em_jogo <= (estado_n == JOGANDO);
        end
    end

    assign estado_atual  = estado;
    assign posicao_atual = posicao;

endmodule

// File: tb/tb_controle_pista.sv
// tb_controle_pista -- self-checking bench for controle_pista
// (TEMPO_LIMITE = 20, TEMPO_RESULTADO = 4).
module tb_controle_pista;

    localparam int LIM = 20;
    localparam int TR  = 4;
    localparam int N   = LIM + TR + 2;   // cycles per game: always ends idle

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       iniciar = 1'b0;
    logic       avancar = 1'b0;
    logic [2:0] estado_atual;
    logic [2:0] posicao_atual;
    logic       em_jogo;

    int errors = 0;
    int checks = 0;

    controle_pista #(.TEMPO_LIMITE(LIM), .TEMPO_RESULTADO(TR)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .iniciar       (iniciar),
        .avancar       (avancar),
        .estado_atual  (estado_atual),
        .posicao_atual (posicao_atual),
        .em_jogo       (em_jogo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ini;
        logic       av;
        logic [2:0] est;
        logic [2:0] pos;
        logic       em;
    } vec_t;

    vec_t tab[15];

    function automatic logic [6:0] obs();
        return {estado_atual, posicao_atual, em_jogo};
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got estado=%b pos=%0d em=%b, want estado=%b pos=%0d em=%b",
                     name, got[6:4], got[3:1], got[0], exp[6:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for one game. s[0] is avancar during the start cycle,
    // s[j] (j>=1) is avancar during the game cycle whose tempo is j-1.
    // The expected trace follows from counting button edges against time.
    task automatic play(input string name, input logic [N-1:0] s,
                        input logic [N-1:0] m, input logic [2:0] want);
        int         endj = -1;
        int         nedge = 0;
        int         upto[N];
        logic [2:0] res, rpos, seen;
        logic [6:0] exp;
        bit         got_seen = 0;
        seen = 3'b111;
        upto[0] = 0;
        for (int j = 1; j < N; j++) begin
            if (endj < 0) begin
                if (s[j] && !s[j-1]) nedge++;
                if (nedge == 5 || j == LIM) endj = j;
            end
            upto[j] = nedge;
        end
        if (nedge == 5) begin
            res  = (endj - 1 < LIM / 2) ? 3'b010 : 3'b011;
            rpos = 3'd5;
        end else begin
            res  = 3'b100;
            rpos = 3'(nedge);
        end
        for (int k = 0; k < N; k++) begin
            iniciar = (k == 0) || (m[k] && k < endj + TR);
            avancar = s[k];
            step();
            if (k < endj)           exp = {3'b001, 3'(upto[k]), 1'b1};
            else if (k < endj + TR) exp = {res, rpos, 1'b0};
            else                    exp = 7'b0;
            check($sformatf("%s_c%0d", name, k), obs(), exp);
            if (!got_seen && k > 0 && estado_atual != 3'b001) begin
                seen = estado_atual;
                got_seen = 1;
            end
        end
        iniciar = 1'b0;
        if (want != 3'b111)
            check($sformatf("%s_outcome", name), {seen, 4'b0}, {want, 4'b0});
    endtask

    initial begin
        logic [N-1:0] s, m;

        // completion at tempo 8: total success, 4 result cycles, back to idle
        tab[0]  = '{1'b1, 1'b0, 3'b001, 3'd0, 1'b1};
        tab[1]  = '{1'b0, 1'b1, 3'b001, 3'd1, 1'b1};
        tab[2]  = '{1'b0, 1'b0, 3'b001, 3'd1, 1'b1};
        tab[3]  = '{1'b0, 1'b1, 3'b001, 3'd2, 1'b1};
        tab[4]  = '{1'b0, 1'b0, 3'b001, 3'd2, 1'b1};
        tab[5]  = '{1'b0, 1'b1, 3'b001, 3'd3, 1'b1};
        tab[6]  = '{1'b0, 1'b0, 3'b001, 3'd3, 1'b1};
        tab[7]  = '{1'b0, 1'b1, 3'b001, 3'd4, 1'b1};
        tab[8]  = '{1'b0, 1'b0, 3'b001, 3'd4, 1'b1};
        tab[9]  = '{1'b0, 1'b1, 3'b010, 3'd5, 1'b0};
        tab[10] = '{1'b0, 1'b0, 3'b010, 3'd5, 1'b0};
        tab[11] = '{1'b1, 1'b1, 3'b010, 3'd5, 1'b0};
        tab[12] = '{1'b0, 1'b0, 3'b010, 3'd5, 1'b0};
        tab[13] = '{1'b0, 1'b1, 3'b000, 3'd0, 1'b0};
        tab[14] = '{1'b0, 1'b0, 3'b000, 3'd0, 1'b0};

        #12;
        check("reset_state", obs(), 7'b0);
        reset_n = 1'b1;
        step();
        check("idle_after_reset", obs(), 7'b0);

        for (int i = 0; i < 15; i++) begin
            iniciar = tab[i].ini;
            avancar = tab[i].av;
            step();
            check($sformatf("tab%0d", i), obs(), {tab[i].est, tab[i].pos, tab[i].em});
        end
        iniciar = 1'b0;
        avancar = 1'b0;

        // completion at tempo 12: partial success
        s = '0; m = '0;
        s[1] = 1; s[3] = 1; s[5] = 1; s[7] = 1; s[13] = 1;
        play("late", s, m, 3'b011);

        // only 3 edges: failure at pos 3, start pulse during failure ignored
        s = '0; m = '0;
        s[1] = 1; s[3] = 1; s[5] = 1; m[21] = 1;
        play("timeout", s, m, 3'b100);

        // fifth edge in the very last cycle (tempo 19) beats the timeout
        s = '0; m = '0;
        s[2] = 1; s[4] = 1; s[6] = 1; s[8] = 1; s[20] = 1;
        play("last_cycle", s, m, 3'b011);

        // avancar held high across start: no edge until it falls and rises
        s = '0; m = '0;
        s[0] = 1; s[1] = 1; s[2] = 1; s[4] = 1; s[6] = 1; m[22] = 1;
        play("held", s, m, 3'b100);

        for (int g = 0; g < 40; g++) begin
            int dens;
            dens = int'($urandom_range(1, 3));
            for (int j = 0; j < N; j++) s[j] = (int'($urandom_range(0, 3)) < dens);
            m = N'($urandom) & N'($urandom);
            play($sformatf("rnd%0d", g), s, m, 3'b111);
        end

        // asynchronous reset in the middle of a game at position 3
        iniciar = 1'b1; avancar = 1'b0;
        step();
        iniciar = 1'b0;
        for (int i = 0; i < 3; i++) begin
            avancar = 1'b1; step();
            avancar = 1'b0; step();
        end
        check("pre_reset_pos3", obs(), {3'b001, 3'd3, 1'b1});
        #2 reset_n = 1'b0;
        #1 check("async_reset", obs(), 7'b0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            avancar = ~avancar;
            step();
            check($sformatf("idle_wait%0d", i), obs(), 7'b0);
        end
        avancar = 1'b0;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        check("restart", obs(), {3'b001, 3'd0, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
